// File: rtl/mux_bit_serializer_if.sv
// rtl/mux_bit_serializer_if.sv - byte handshake and 8->1 selector drive bundle
interface mux_bit_serializer_if;
  logic [7:0] DIN;
  logic       DIN_VALID;
  logic       DIN_READY;
  logic [7:0] D;
  logic [2:0] S;
  logic       N_E;
  logic       BUSY;
  logic       DONE;

  modport master (
    output DIN, DIN_VALID,
    input  DIN_READY, D, S, N_E, BUSY, DONE
  );

  modport slave (
    input  DIN, DIN_VALID,
    output DIN_READY, D, S, N_E, BUSY, DONE
  );
endinterface

// File: rtl/mux_bit_serializer.sv
// rtl/mux_bit_serializer.sv - sequences bytes through an 8->1 line selector as a serial stream
// Double-buffered (active D + HOLD) so back-to-back bytes leave no idle bit period.
module mux_bit_serializer #(
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic CLK,
  input logic N_RST,
  mux_bit_serializer_if.slave bus
);

  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DCW-1:0] DC_LAST = DCW'(DIV - 1);
  localparam logic [2:0] FIRST = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST  = MSB_FIRST ? 3'd0 : 3'd7;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]     state;
  logic [7:0]     d_q;
  logic [2:0]     s_q;
  logic           n_e_q;
  logic           busy_q;
  logic           done_q;
  logic [7:0]     hold;
  logic           hold_full;
  logic [DCW-1:0] dc;

  logic accept;
  logic boundary;
  logic [2:0] s_next;

  assign bus.DIN_READY = !hold_full;
  assign accept   = bus.DIN_VALID && !hold_full;
  assign boundary = (state == ST_SHIFT) && (dc == DC_LAST) && (s_q == LAST);
  assign s_next   = MSB_FIRST ? (s_q - 3'd1) : (s_q + 3'd1);

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state     <= ST_IDLE;
      d_q       <= 8'h00;
      s_q       <= 3'b000;
      n_e_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hold      <= 8'h00;
      hold_full <= 1'b0;
      dc        <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            d_q    <= bus.DIN;
            s_q    <= FIRST;
            dc     <= '0;
            n_e_q  <= 1'b0;
            busy_q <= 1'b1;
            state  <= ST_SHIFT;
          end
        end
        default: begin
          if (dc != DC_LAST) begin
            dc <= dc + 1'b1;
          end else if (s_q != LAST) begin
            s_q <= s_next;
            dc  <= '0;
          end else begin
            done_q <= 1'b1;
            dc     <= '0;
            if (hold_full) begin
              d_q       <= hold;
              hold_full <= 1'b0;
              s_q       <= FIRST;
            end else if (accept) begin
              // Byte arriving exactly on the boundary skips HOLD to avoid a gap.
              d_q <= bus.DIN;
              s_q <= FIRST;
            end else begin
              n_e_q  <= 1'b1;
              busy_q <= 1'b0;
              state  <= ST_IDLE;
            end
          end
          if (accept && !boundary) begin
            hold      <= bus.DIN;
            hold_full <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.D    = d_q;
  assign bus.S    = s_q;
  assign bus.N_E  = n_e_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;

  a_div_legal: assert property (@(posedge CLK) (DIV >= 1) && (DIV <= 256));
  a_ne_busy:   assert property (@(posedge CLK) disable iff (!N_RST) n_e_q == !busy_q);
  a_hold_busy: assert property (@(posedge CLK) disable iff (!N_RST) hold_full |-> busy_q);
  a_done_bnd:  assert property (@(posedge CLK) disable iff (!N_RST) done_q |-> $past(boundary));
  a_dc_range:  assert property (@(posedge CLK) disable iff (!N_RST) int'(dc) < DIV);

endmodule
